// File: rtl/hazard_control_unit.sv
// Pipeline hazard/stall controller: load-use and branch-operand stalls, memory-wait freeze,
// multi-cycle trap flush sequencing and a saturating stall counter for performance monitoring.
module hazard_control_unit #(
    parameter int FlushCycles  = 2,
    parameter int CounterWidth = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              id_forward_type,
    input  logic [4:0]              id_rs1,
    input  logic [4:0]              id_rs2,
    input  logic                    ex_reg_we,
    input  logic                    ex_mem_read,
    input  logic [4:0]              ex_rd,
    input  logic                    mem_reg_we,
    input  logic                    mem_mem_read,
    input  logic [4:0]              mem_rd,
    input  logic                    mem_access,
    input  logic                    mem_ack,
    input  logic                    branch_taken,
    input  logic                    trap,
    output logic                    pc_en,
    output logic                    if_id_en,
    output logic                    id_ex_en,
    output logic                    ex_mem_en,
    output logic                    mem_wb_en,
    output logic                    if_id_flush,
    output logic                    id_ex_flush,
    output logic                    ex_mem_flush,
    output logic                    mem_wb_flush,
    output logic [CounterWidth-1:0] stall_count
);

    typedef enum logic {RUN, FLUSH} hazardState;

    // The cycle a trap is applied is itself the first flush cycle, so FLUSH covers the rest.
    localparam logic [2:0] FlushReload = 3'(FlushCycles - 1);
    localparam bit         FlushMulti  = (FlushCycles > 1);

    hazardState             state;
    logic                   trapPending;
    logic [2:0]             flushCnt;
    logic [CounterWidth-1:0] stallCount;

    logic exHit1, exHit2, memHit1, memHit2;
    logic dataHazard, memWait, trapNow;

    function automatic logic hit(input logic [4:0] rs, input logic [4:0] rd, input logic we);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

    always_comb begin
        exHit1  = hit(id_rs1, ex_rd, ex_reg_we);
        exHit2  = hit(id_rs2, ex_rd, ex_reg_we);
        memHit1 = hit(id_rs1, mem_rd, mem_reg_we);
        memHit2 = hit(id_rs2, mem_rd, mem_reg_we);
        unique case (id_forward_type)
            2'd1:    dataHazard = (exHit1 || exHit2) && ex_mem_read;
            2'd2:    dataHazard = exHit1 || exHit2 || ((memHit1 || memHit2) && mem_mem_read);
            2'd3:    dataHazard = exHit1 && ex_mem_read;
            default: dataHazard = 1'b0;
        endcase
        memWait = mem_access && !mem_ack;
        trapNow = trap || trapPending;
    end

    // Strobe selection in priority order: flush sequence, freeze, trap, data hazard, branch.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (state == FLUSH || (!memWait && trapNow)) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (memWait) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (dataHazard) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            trapPending <= 1'b0;
            flushCnt    <= 3'd0;
            stallCount  <= '0;
        end else begin
            if (!pc_en && stallCount != {CounterWidth{1'b1}})
                stallCount <= stallCount + {{(CounterWidth-1){1'b0}}, 1'b1};
            unique case (state)
                RUN: begin
                    if (memWait) begin
                        if (trap)
                            trapPending <= 1'b1;
                    end else if (trapNow) begin
                        trapPending <= 1'b0;
                        flushCnt    <= FlushReload;
                        state       <= FlushMulti ? FLUSH : RUN;
                    end
                end
                FLUSH: begin
                    // A fresh trap restarts the sequence from its own arrival cycle.
                    if (trap) begin
                        flushCnt <= FlushReload;
                    end else if (flushCnt <= 3'd1) begin
                        flushCnt <= 3'd0;
                        state    <= RUN;
                    end else begin
                        flushCnt <= flushCnt - 3'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign stall_count = stallCount;

endmodule
